// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one uart_tx among four byte producers
// Optional debug state port enabled by defining UART_TX_ARB_DBG_EN.
module uart_tx_arb #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy,
  output logic        busy,
  output logic        err
`ifdef UART_TX_ARB_DBG_EN
  ,
  output logic [1:0]  state_out_dbg
`endif
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    last;
  logic [CW-1:0] cnt;
  logic [1:0]    win;
  logic          win_found;
  logic [1:0]    cand;

  // Rotating priority search: first set request bit starting just above the previous winner.
  always_comb begin
    win       = last;
    win_found = 1'b0;
    cand      = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + k[1:0];
      if (!win_found && req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  // Arbitration FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 2'd3;
      gnt     <= 4'b0000;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
      err     <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
    end else begin
      gnt   <= 4'b0000;
      tx_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found && tx_rdy) begin
            tx_data <= req_data[{win, 3'b000} +: 8];
            gnt     <= 4'b0001 << win;
            tx_en   <= 1'b1;
            last    <= win;
            state   <= LAUNCH;
            busy    <= 1'b1;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!tx_rdy) begin
            state <= WAIT_HIGH;
          end else if (cnt == CNT_MAX) begin
            // Transmitter never accepted the byte: drop it and report.
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (tx_rdy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_ARB_DBG_EN
  assign state_out_dbg = state;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        busy;
  logic        err;
`ifdef UART_TX_ARB_DBG_EN
  logic [1:0]  state_out_dbg;
`endif

  uart_tx_arb #(.TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .tx_rdy(tx_rdy),
    .busy(busy),
    .err(err)
`ifdef UART_TX_ARB_DBG_EN
    ,
    .state_out_dbg(state_out_dbg)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // transmitter model: drops rdy on launch, holds it low frame_len cycles
  bit auto_en = 1'b0;
  int frame_len = 3;
  int left = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_en) begin
      if (left > 0) begin
        left--;
        if (left == 0) tx_rdy = 1'b1;
      end
      if (tx_en) begin
        tx_rdy = 1'b0;
        left = frame_len;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tx_rdy = 1'b1;
    left = 0;
    tick();
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
  endtask

  function automatic int rr(input logic [3:0] r, input int l);
    for (int k = 1; k <= 4; k++)
      if (r[(l + k) % 4]) return (l + k) % 4;
    return -1;
  endfunction

  initial begin
    int n;
    bit seen;
    logic [7:0] bytes[4];
    bit pend[4];
    int mlast, free_at, w, c;
    logic [3:0] exp_g;
    logic [7:0] exp_d, last_d;

    tbl[0] = '{4'b0100, 32'h00030000, 4'b0100, 8'h03};
    tbl[1] = '{4'b0101, 32'h44332211, 4'b0001, 8'h11};
    tbl[2] = '{4'b1010, 32'h44332211, 4'b0010, 8'h22};
    tbl[3] = '{4'b1010, 32'h44332211, 4'b1000, 8'h44};
    tbl[4] = '{4'b1111, 32'h8899AABB, 4'b0001, 8'hBB};
    tbl[5] = '{4'b0001, 32'h8899AABB, 4'b0001, 8'hBB};
    tbl[6] = '{4'b1100, 32'h8899AABB, 4'b0100, 8'h99};
    tbl[7] = '{4'b0100, 32'h01020304, 4'b0100, 8'h02};

    rst = 1'b1;
    req = 4'b0000;
    req_data = 32'd0;
    tx_rdy = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // table of single launches, rotation carried over between rows
    auto_en = 1'b1;
    frame_len = 3;
    for (int r = 0; r < 8; r++) begin
      req = tbl[r].req;
      req_data = tbl[r].data;
      tick();
      check($sformatf("row%0d_gnt", r), {28'd0, gnt}, {28'd0, tbl[r].exp_gnt});
      check($sformatf("row%0d_tx_en", r), {31'd0, tx_en}, 32'd1);
      check($sformatf("row%0d_tx_data", r), {24'd0, tx_data}, {24'd0, tbl[r].exp_byte});
      check($sformatf("row%0d_busy", r), {31'd0, busy}, 32'd1);
      req = 4'b0000;
      tick();
      check($sformatf("row%0d_gnt_pulse", r), {27'd0, tx_en, gnt}, 32'd0);
      check($sformatf("row%0d_data_hold", r), {24'd0, tx_data}, {24'd0, tbl[r].exp_byte});
      n = 1;
      while (busy && n < 30) begin
        tick();
        n++;
      end
      check($sformatf("row%0d_busy_len", r), n, 4);
    end

    // round robin with all four requesting continuously
    do_reset();
    frame_len = 2;
    req = 4'hF;
    req_data = 32'hA3A2A1A0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (gnt == 4'b0000 && n < 20);
      check($sformatf("rr%0d_gnt", k), {28'd0, gnt}, 32'd1 << (k % 4));
      check($sformatf("rr%0d_data", k), {24'd0, tx_data}, 32'hA0 + (k % 4));
      if (k > 0) check($sformatf("rr%0d_gap", k), n, 4);
    end
    req = 4'b0000;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end

    // transmitter busy: no grant while rdy low
    auto_en = 1'b0;
    tx_rdy = 1'b0;
    req = 4'b0001;
    req_data = 32'h000000C5;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (gnt != 4'b0000 || tx_en) seen = 1'b1;
    end
    check("rdy_low_no_grant", {31'd0, seen}, 32'd0);
    tx_rdy = 1'b1;
    tick();
    check("rdy_rise_gnt", {28'd0, gnt}, 32'd1);
    check("rdy_rise_tx_en", {31'd0, tx_en}, 32'd1);

    // timeout: rdy stays high after launch
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    check("timeout_latency", n, 17);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    tick();
    check("timeout_err_pulse", {31'd0, err}, 32'd0);
    check("timeout_regrant", {28'd0, gnt}, 32'd1);
    req = 4'b0000;
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    check("timeout2_latency", n, 17);
    tick();

    // reset in the middle of a frame
    auto_en = 1'b1;
    left = 0;
    frame_len = 10;
    req = 4'b0010;
    req_data = 32'h00005A00;
    tick();
    check("mid_gnt", {28'd0, gnt}, 32'd2);
    req = 4'b0000;
    tick();
    tick();
    do_reset();
    req = 4'hF;
    tick();
    check("post_rst_gnt", {28'd0, gnt}, 32'd1);
    req = 4'b0000;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("post_rst_busy_len", n, 11);

    // randomized producers against a transaction-level model
    do_reset();
    frame_len = 2;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      bytes[i] = 8'h00;
    end
    mlast = 3;
    free_at = cyc;
    last_d = 8'h00;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          bytes[i] = 8'($urandom);
        end
      end
      req = {pend[3], pend[2], pend[1], pend[0]};
      req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
      frame_len = $urandom_range(2, 6);
      c = cyc;
      exp_g = 4'b0000;
      exp_d = last_d;
      w = -1;
      if (c >= free_at && req != 4'b0000) begin
        w = rr(req, mlast);
        exp_g = 4'b0001 << w;
        exp_d = bytes[w];
        mlast = w;
        free_at = c + 1 + frame_len + 1;
      end
      tick();
      check("rand_gnt", {28'd0, gnt}, {28'd0, exp_g});
      check("rand_tx_en", {31'd0, tx_en}, {31'd0, (exp_g != 4'b0000)});
      check("rand_tx_data", {24'd0, tx_data}, {24'd0, exp_d});
      check("rand_busy", {31'd0, busy}, {31'd0, (cyc < free_at)});
      check("rand_err", {31'd0, err}, 32'd0);
      last_d = exp_d;
      if (w >= 0) pend[w] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
